flop_fifo_rv: RTL and testbench

//  Flop-based circular-buffer FIFO, pointer-addressed. Storage does not shift on push.

---
 rtl/flop_fifo_rv.sv | 145 ++++++++++++++
 tb/tb_flop_fifo_rv.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flop_fifo_rv.sv
// rtl/flop_fifo_rv.sv - pointer-addressed flop FIFO with registered ready/count and optional prefetch head register
module flop_fifo_rv #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int OUTPUT_REG = 0,
    localparam int CAP       = DEPTH + OUTPUT_REG,
    localparam int CNT_W     = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_rst_n,
    input  logic [CNT_W-1:0] cfg_watermark,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             data_valid,
    output logic [CNT_W-1:0] count,
    output logic             half_full,
    output logic             watermark,
    output logic             ovf_err,
    output logic             unf_err,
    input  logic             clr_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(CAP >> 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_push_rdy;
    logic             r_ovf;
    logic             r_unf;

    logic             w_push_acc;
    logic             w_pop_acc;
    logic             w_data_valid;
    logic             w_mem_we;
    logic             w_mem_re;
    logic [CNT_W-1:0] w_count_nxt;

    // Explicit wrap so non-power-of-two depths never address past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_push_acc  = push & r_push_rdy;
    assign w_pop_acc   = pop & w_data_valid;
    assign w_count_nxt = r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_acc);

    generate
        if (OUTPUT_REG == 0) begin : g_comb_out
            assign w_data_valid = (r_count != '0);
            assign w_mem_we     = w_push_acc;
            assign w_mem_re     = w_pop_acc;
            assign pop_data     = w_data_valid ? r_mem[r_rd_ptr] : '0;
        end else begin : g_reg_out
            logic             r_ov;
            logic [WIDTH-1:0] r_oreg;
            logic             w_arr_ne;
            logic             w_take;
            logic             w_load_arr;
            logic             w_load_push;

            // The array holds everything except the head parked in the output register.
            assign w_arr_ne    = (r_count != CNT_W'(r_ov));
            assign w_take      = w_pop_acc | ~r_ov;
            assign w_load_arr  = w_take & w_arr_ne;
            assign w_load_push = w_take & ~w_arr_ne & w_push_acc;
            assign w_mem_we    = w_push_acc & ~w_load_push;
            assign w_mem_re    = w_load_arr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ov   <= 1'b0;
                    r_oreg <= '0;
                end else if (!sync_rst_n) begin
                    r_ov   <= 1'b0;
                    r_oreg <= '0;
                end else if (w_load_arr) begin
                    r_ov   <= 1'b1;
                    r_oreg <= r_mem[r_rd_ptr];
                end else if (w_load_push) begin
                    r_ov   <= 1'b1;
                    r_oreg <= push_data;
                end else if (w_pop_acc) begin
                    r_ov   <= 1'b0;
                end
            end

            assign w_data_valid = r_ov;
            assign pop_data     = r_ov ? r_oreg : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_push_rdy <= 1'b1;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (!sync_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_push_rdy <= 1'b1;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_mem_re) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count    <= w_count_nxt;
            r_push_rdy <= (w_count_nxt < CAP_C);
            // A new error event outranks a simultaneous clear.
            r_ovf      <= (push & ~r_push_rdy) | (r_ovf & ~clr_err);
            r_unf      <= (pop & ~w_data_valid) | (r_unf & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && sync_rst_n && w_mem_we) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign push_rdy   = r_push_rdy;
    assign data_valid = w_data_valid;
    assign count      = r_count;
    assign half_full  = (r_count >= HALF_C);
    assign watermark  = (r_count >= cfg_watermark);
    assign ovf_err    = r_ovf;
    assign unf_err    = r_unf;

endmodule

// File: tb/tb_flop_fifo_rv.sv
// tb/tb_flop_fifo_rv.sv - scoreboard bench for flop_fifo_rv in three depth/output-register configurations
module tb_flop_fifo_rv;

    logic       clk;
    logic       rst_n;
    logic       sync_rst_n;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [7:0] push_data;
    logic [2:0] cfg_wm4;
    logic [1:0] cfg_wm3;

    logic       rdy_a, dv_a, hf_a, wm_a, ovf_a, unf_a;
    logic [7:0] pd_a;
    logic [2:0] cnt_a;
    logic       rdy_b, dv_b, hf_b, wm_b, ovf_b, unf_b;
    logic [7:0] pd_b;
    logic [1:0] cnt_b;
    logic       rdy_c, dv_c, hf_c, wm_c, ovf_c, unf_c;
    logic [7:0] pd_c;
    logic [1:0] cnt_c;

    flop_fifo_rv #(.WIDTH(8), .DEPTH(4), .OUTPUT_REG(0)) u_d4 (
        .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n), .cfg_watermark(cfg_wm4),
        .push(push), .push_data(push_data), .push_rdy(rdy_a), .pop(pop), .pop_data(pd_a),
        .data_valid(dv_a), .count(cnt_a), .half_full(hf_a), .watermark(wm_a),
        .ovf_err(ovf_a), .unf_err(unf_a), .clr_err(clr_err));

    flop_fifo_rv #(.WIDTH(8), .DEPTH(3), .OUTPUT_REG(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n), .cfg_watermark(cfg_wm3),
        .push(push), .push_data(push_data), .push_rdy(rdy_b), .pop(pop), .pop_data(pd_b),
        .data_valid(dv_b), .count(cnt_b), .half_full(hf_b), .watermark(wm_b),
        .ovf_err(ovf_b), .unf_err(unf_b), .clr_err(clr_err));

    flop_fifo_rv #(.WIDTH(8), .DEPTH(2), .OUTPUT_REG(1)) u_d2r (
        .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n), .cfg_watermark(cfg_wm3),
        .push(push), .push_data(push_data), .push_rdy(rdy_c), .pop(pop), .pop_data(pd_c),
        .data_valid(dv_c), .count(cnt_c), .half_full(hf_c), .watermark(wm_c),
        .ovf_err(ovf_c), .unf_err(unf_c), .clr_err(clr_err));

    int         sel;
    logic       m_rdy, m_dv, m_hf, m_wm, m_ovf, m_unf;
    logic [7:0] m_pd;
    logic [2:0] m_cnt;

    always_comb begin
        m_rdy = rdy_a; m_dv = dv_a; m_hf = hf_a; m_wm = wm_a; m_ovf = ovf_a; m_unf = unf_a;
        m_pd = pd_a; m_cnt = cnt_a;
        if (sel == 1) begin
            m_rdy = rdy_b; m_dv = dv_b; m_hf = hf_b; m_wm = wm_b; m_ovf = ovf_b; m_unf = unf_b;
            m_pd = pd_b; m_cnt = {1'b0, cnt_b};
        end else if (sel == 2) begin
            m_rdy = rdy_c; m_dv = dv_c; m_hf = hf_c; m_wm = wm_c; m_ovf = ovf_c; m_unf = unf_c;
            m_pd = pd_c; m_cnt = {1'b0, cnt_c};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_fail;
    int         mcnt;
    int         mcap;
    logic [7:0] sb [$];
    logic       acc_pop;
    logic       acc_push;
    logic [7:0] exp_pd;
    logic [7:0] obs_pd;
    logic       obs_dv;

    // Drives one cycle; the reference queue decides acceptance from its own occupancy.
    task automatic drive(input logic p, input logic [7:0] d, input logic r, input logic c);
        push = p; push_data = d; pop = r; clr_err = c;
        obs_pd = m_pd; obs_dv = m_dv;
        acc_pop  = r && (mcnt > 0);
        acc_push = p && (mcnt < mcap);
        if (acc_pop) exp_pd = sb.pop_front();
        if (acc_push) sb.push_back(d);
        mcnt = mcnt + int'(acc_push) - int'(acc_pop);
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic sreset(input int s, input int cap);
        sel = s; mcap = cap;
        sync_rst_n = 1'b0;
        @(posedge clk); #1;
        sync_rst_n = 1'b1;
        sb.delete(); mcnt = 0;
    endtask

    task automatic test_reset();
        sel = 0; mcap = 4; cfg_wm4 = 3'd0;
        n_checks++; if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b exp 1", m_rdy); end
        n_checks++; if (m_dv !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %b exp 0", m_dv); end
        n_checks++; if (m_pd !== 8'h00) begin n_fail++; $display("FAIL rst_pd: got %h exp 00", m_pd); end
        n_checks++; if (m_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", m_cnt); end
        n_checks++; if (m_hf !== 1'b0) begin n_fail++; $display("FAIL rst_hf: got %b exp 0", m_hf); end
        n_checks++; if (m_wm !== 1'b1) begin n_fail++; $display("FAIL rst_wm0: got %b exp 1", m_wm); end
        n_checks++; if ({m_ovf, m_unf} !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b exp 00", {m_ovf, m_unf}); end
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        n_checks++; if (m_cnt !== 3'd3) begin n_fail++; $display("FAIL rst_pre_cnt: got %0d exp 3", m_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (m_cnt !== 3'd0) begin n_fail++; $display("FAIL async_cnt: got %0d exp 0", m_cnt); end
        n_checks++; if (m_dv !== 1'b0) begin n_fail++; $display("FAIL async_dv: got %b exp 0", m_dv); end
        n_checks++; if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL async_rdy: got %b exp 1", m_rdy); end
        n_checks++; if (m_pd !== 8'h00) begin n_fail++; $display("FAIL async_pd: got %h exp 00", m_pd); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sb.delete(); mcnt = 0;
    endtask

    task automatic test_fill_drain();
        sreset(0, 4); cfg_wm4 = 3'd3;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
            n_checks++; if (m_cnt !== 3'(mcnt)) begin n_fail++; $display("FAIL fill_cnt: got %0d exp %0d", m_cnt, mcnt); end
            n_checks++; if (m_hf !== (mcnt >= 2)) begin n_fail++; $display("FAIL fill_hf: got %b at count %0d", m_hf, mcnt); end
            n_checks++; if (m_wm !== (mcnt >= 3)) begin n_fail++; $display("FAIL fill_wm: got %b at count %0d", m_wm, mcnt); end
            n_checks++; if (m_rdy !== (mcnt < 4)) begin n_fail++; $display("FAIL fill_rdy: got %b at count %0d", m_rdy, mcnt); end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (obs_pd !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL drain_data: got %h exp %h", obs_pd, 8'(8'hA0 + i)); end
            n_checks++; if (!acc_pop || obs_pd !== exp_pd) begin n_fail++; $display("FAIL drain_sb: got %h exp %h", obs_pd, exp_pd); end
        end
        n_checks++; if (m_dv !== 1'b0) begin n_fail++; $display("FAIL drain_dv: got %b exp 0", m_dv); end
        n_checks++; if (m_pd !== 8'h00) begin n_fail++; $display("FAIL drain_pd: got %h exp 00", m_pd); end
    endtask

    task automatic test_overflow();
        sreset(0, 4);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        n_checks++; if (obs_pd !== exp_pd) begin n_fail++; $display("FAIL ovf_pop: got %h exp %h", obs_pd, exp_pd); end
        n_checks++; if (m_cnt !== 3'd3) begin n_fail++; $display("FAIL ovf_cnt: got %0d exp 3", m_cnt); end
        n_checks++; if (m_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b exp 1", m_ovf); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b exp 0", m_ovf); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (obs_pd !== exp_pd) begin n_fail++; $display("FAIL ovf_drain: got %h exp %h", obs_pd, exp_pd); end
        end
        n_checks++; if (m_dv !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b exp 0", m_dv); end
    endtask

    task automatic test_underflow();
        sreset(0, 4);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (m_unf !== 1'b1) begin n_fail++; $display("FAIL unf_setwins: got %b exp 1", m_unf); end
        n_checks++; if (m_cnt !== 3'd0) begin n_fail++; $display("FAIL unf_cnt: got %0d exp 0", m_cnt); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (m_unf !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got %b exp 1", m_unf); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (m_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clr: got %b exp 0", m_unf); end
    endtask

    task automatic test_sync_reset();
        sreset(0, 4);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'h70, 1'b0, 1'b0);
        drive(1'b1, 8'h71, 1'b0, 1'b0);
        sync_rst_n = 1'b0; push = 1'b1; push_data = 8'h77;
        @(posedge clk); #1;
        sync_rst_n = 1'b1; push = 1'b0;
        sb.delete(); mcnt = 0;
        n_checks++; if (m_cnt !== 3'd0) begin n_fail++; $display("FAIL srst_cnt: got %0d exp 0", m_cnt); end
        n_checks++; if (m_dv !== 1'b0) begin n_fail++; $display("FAIL srst_dv: got %b exp 0", m_dv); end
        n_checks++; if (m_unf !== 1'b0) begin n_fail++; $display("FAIL srst_unf: got %b exp 0", m_unf); end
        drive(1'b1, 8'h78, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (obs_pd !== 8'h78) begin n_fail++; $display("FAIL srst_data: got %h exp 78", obs_pd); end
    endtask

    task automatic test_wrap();
        sreset(1, 3);
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 2; i <= 10; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            n_checks++; if (obs_pd !== 8'(i - 1)) begin n_fail++; $display("FAIL wrap_data: got %h exp %h", obs_pd, 8'(i - 1)); end
            n_checks++; if (m_cnt !== 3'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d exp 1", m_cnt); end
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (obs_pd !== 8'h0A) begin n_fail++; $display("FAIL wrap_last: got %h exp 0a", obs_pd); end
        n_checks++; if (m_dv !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b exp 0", m_dv); end
    endtask

    task automatic test_oreg();
        sreset(2, 3); cfg_wm3 = 2'd2;
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        n_checks++; if ({m_dv, m_pd} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL oreg_first: got %b/%h exp 1/11", m_dv, m_pd); end
        n_checks++; if ({m_cnt, m_wm, m_hf} !== {3'd1, 1'b0, 1'b1}) begin n_fail++; $display("FAIL oreg_c1: got %0d/%b/%b exp 1/0/1", m_cnt, m_wm, m_hf); end
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        n_checks++; if ({m_cnt, m_wm, m_rdy} !== {3'd2, 1'b1, 1'b1}) begin n_fail++; $display("FAIL oreg_c2: got %0d/%b/%b exp 2/1/1", m_cnt, m_wm, m_rdy); end
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        n_checks++; if ({m_cnt, m_wm, m_rdy} !== {3'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL oreg_full: got %0d/%b/%b exp 3/1/0", m_cnt, m_wm, m_rdy); end
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        n_checks++; if ({m_cnt, m_ovf} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL oreg_drop: got %0d/%b exp 3/1", m_cnt, m_ovf); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (obs_pd !== exp_pd) begin n_fail++; $display("FAIL oreg_pop: got %h exp %h", obs_pd, exp_pd); end
        end
        drive(1'b1, 8'h66, 1'b1, 1'b0);
        n_checks++; if (obs_pd !== 8'h33) begin n_fail++; $display("FAIL oreg_bypass_pop: got %h exp 33", obs_pd); end
        n_checks++; if ({m_cnt, m_pd} !== {3'd1, 8'h66}) begin n_fail++; $display("FAIL oreg_bypass: got %0d/%h exp 1/66", m_cnt, m_pd); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if ({m_dv, m_pd, m_wm} !== {1'b0, 8'h00, 1'b0}) begin n_fail++; $display("FAIL oreg_empty: got %b/%h/%b exp 0/00/0", m_dv, m_pd, m_wm); end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            sreset(s, (s == 0) ? 4 : 3);
            for (int k = 0; k < 60; k++) begin
                drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                if (acc_pop) begin
                    n_checks++; if (obs_pd !== exp_pd) begin n_fail++; $display("FAIL b2b_data s%0d: got %h exp %h", s, obs_pd, exp_pd); end
                end
                n_checks++; if (m_cnt !== 3'(mcnt)) begin n_fail++; $display("FAIL b2b_cnt s%0d: got %0d exp %0d", s, m_cnt, mcnt); end
                n_checks++; if ({m_rdy, m_dv} !== {mcnt < mcap, mcnt > 0}) begin n_fail++; $display("FAIL b2b_flags s%0d: got %b%b at count %0d", s, m_rdy, m_dv, mcnt); end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; mcnt = 0; mcap = 4; sel = 0;
        rst_n = 1'b0; sync_rst_n = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        push_data = 8'h00; cfg_wm4 = 3'd0; cfg_wm3 = 2'd0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_sync_reset();
        test_wrap();
        test_oreg();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
